reg_nb_univ: RTL and testbench
==============================

REG_NB_UNIV -- requirements
Module: reg_nb_univ

Interface
REQ-001 Parameter: n, default 8, data width in bits; SHALL support n >= 1.
REQ-002 Parameter: RST_VAL, default 0, n-bit value loaded on clear.
REQ-003 Port: clk  input  1  rising-edge clock; the block SHALL use one clock.
REQ-004 Port: clr  input  1  reset; synchronous, active-high.
REQ-005 Port: en  input  1  operation enable; 0 = hold.
REQ-006 Port: mode  input  3  operation select; encoding per REQ-011.
REQ-007 Port: data_in  input  n  parallel load value.
REQ-008 Port: sin  input  1  serial input for shift modes.
REQ-009 Port: data_out  output  n  register contents.
REQ-010 Port: sout  output  1  registered last bit shifted or rotated out; co  output  1  registered carry/borrow pulse; tc  output  1  combinational terminal-count flag.

Function
REQ-011 Mode encoding SHALL be: 000 hold, 001 load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 count up, 111 count down.
REQ-012 All state SHALL update only on rising clk; priority SHALL be clr > en=0 > mode.
REQ-013 Load: data_out <= data_in with 1-cycle latency.
REQ-014 Shift left: data_out <= {data_out[n-2:0], sin}; sout <= old data_out[n-1]. For n=1: data_out <= sin.
REQ-015 Shift right: data_out <= {sin, data_out[n-1:1]}; sout <= old data_out[0].
REQ-016 Rotate left/right: same as shift, with the outgoing bit fed back in place of sin; sout <= the outgoing bit.
REQ-017 sout SHALL hold its value in every mode other than shift/rotate, and while en=0.
REQ-018 Count up: data_out <= data_out + 1 modulo 2^n; co SHALL be 1 for exactly the cycle following a wrap from all-ones to zero.
REQ-019 Count down: data_out <= data_out - 1 modulo 2^n; co SHALL be 1 for exactly the cycle following a wrap from zero to all-ones.
REQ-020 co SHALL be 0 after any edge without a wrap, including edges with en=0 or a non-count mode.
REQ-021 tc SHALL be 1 when (mode=110 and data_out all-ones) or (mode=111 and data_out zero), regardless of en; otherwise 0.
REQ-022 Changing mode between cycles SHALL take effect on the next edge, with no intermediate state.

Reset
REQ-023 On an edge with clr=1: data_out <= RST_VAL, sout <= 0, co <= 0, regardless of en, mode, or an operation in progress.
REQ-024 clr SHALL have no asynchronous effect; between edges, outputs SHALL hold their prior values.

Configuration
REQ-025 Macro REG_UNIV_CNT_EN defined: count modes SHALL behave per REQ-018..021.
REQ-026 Macro REG_UNIV_CNT_EN undefined: modes 110/111 SHALL act as hold, co and tc SHALL be tied to 0, and no adder logic SHALL be synthesised.

Structure
REQ-027 Package reg_univ_pkg SHALL hold the mode encoding constants (MODE_HOLD ... MODE_CNT_DN) and the mode width constant 3.
REQ-028 Next-value selection SHALL be a combinational sub-module reg_univ_next (inputs data_out, data_in, sin, mode; outputs next value, outgoing bit, wrap); the top SHALL hold only the registers.

Verification
REQ-029 n=8, clr=1 for one edge with RST_VAL=8'hA5, mode=001, data_in=8'h3C -> data_out=8'hA5, sout=0, co=0.
REQ-030 Load 8'h81, shift left with sin=0 for one edge -> data_out=8'h02, sout=1; then rotate right for one edge -> data_out=8'h01, sout=0.
REQ-031 Load 8'hFE, count up for 2 edges -> data_out 8'hFF with tc=1 and co=0, then 8'h00 with co=1 for one cycle only; the next count edge -> co=0.
REQ-032 Load 8'h00, en=0, mode=111 -> data_out stays 8'h00 with tc=1 and co=0; raise en for one edge -> data_out=8'hFF, co=1.
REQ-033 Mid-count, assert clr together with en=1, mode=110 -> data_out=RST_VAL, co=0 on that edge.
REQ-034 Build without REG_UNIV_CNT_EN, load 8'h10, mode=110 for 3 edges -> data_out stays 8'h10, co=0, tc=0.

Source files
------------

// File: rtl/reg_univ_pkg.sv
// rtl/reg_univ_pkg.sv - mode encoding for the universal register; count modes gated by REG_UNIV_CNT_EN
package reg_univ_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_SHL    = 3'b010,
    MODE_SHR    = 3'b011,
    MODE_ROL    = 3'b100,
    MODE_ROR    = 3'b101,
    MODE_CNT_UP = 3'b110,
    MODE_CNT_DN = 3'b111
  } mode_e;

  // Shift and rotate are the only modes that move a bit out through sout.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/reg_univ_next.sv
// rtl/reg_univ_next.sv - combinational next-value, outgoing-bit and wrap selection
// Count datapath exists only when REG_UNIV_CNT_EN is defined.
module reg_univ_next
  import reg_univ_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [n-1:0]      data_out,
  input  logic [n-1:0]      data_in,
  input  logic              sin,
  input  logic [MODE_W-1:0] mode,
  output logic [n-1:0]      next_val,
  output logic              out_bit,
  output logic              wrap
);

  logic [n-1:0] fill_lo;
  logic [n-1:0] fill_hi;

  always_comb begin
    fill_lo  = '0;
    fill_hi  = '0;
    next_val = data_out;
    out_bit  = 1'b0;
    wrap     = 1'b0;
    case (mode_e'(mode))
      MODE_LOAD: next_val = data_in;
      MODE_SHL: begin
        fill_lo[0] = sin;
        next_val   = (data_out << 1) | fill_lo;
        out_bit    = data_out[n-1];
      end
      MODE_SHR: begin
        fill_hi[0] = sin;
        next_val   = (data_out >> 1) | (fill_hi << (n - 1));
        out_bit    = data_out[0];
      end
      // Shift/OR form keeps n=1 legal: no part-select below bit 0.
      MODE_ROL: begin
        fill_lo[0] = data_out[n-1];
        next_val   = (data_out << 1) | fill_lo;
        out_bit    = data_out[n-1];
      end
      MODE_ROR: begin
        fill_hi[0] = data_out[0];
        next_val   = (data_out >> 1) | (fill_hi << (n - 1));
        out_bit    = data_out[0];
      end
`ifdef REG_UNIV_CNT_EN
      MODE_CNT_UP: begin
        next_val = data_out + n'(1);
        wrap     = &data_out;
      end
      MODE_CNT_DN: begin
        next_val = data_out - n'(1);
        wrap     = ~|data_out;
      end
`endif
      default: next_val = data_out;
    endcase
  end

endmodule

// File: rtl/reg_nb_univ.sv
// rtl/reg_nb_univ.sv - n-bit universal register: load, shift, rotate, optional count (REG_UNIV_CNT_EN)
module reg_nb_univ
  import reg_univ_pkg::*;
#(
  parameter int         n       = 8,
  parameter logic [n-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [n-1:0]      data_in,
  input  logic              sin,
  output logic [n-1:0]      data_out,
  output logic              sout,
  output logic              co,
  output logic              tc
);

  logic [n-1:0] data_q, data_d;
  logic         sout_q, sout_d;
  logic         co_q, co_d;
  logic [n-1:0] next_val;
  logic         out_bit;
  logic         wrap;

  reg_univ_next #(.n(n)) u_next (
    .data_out (data_q),
    .data_in  (data_in),
    .sin      (sin),
    .mode     (mode),
    .next_val (next_val),
    .out_bit  (out_bit),
    .wrap     (wrap)
  );

  // co is a one-edge pulse, so it defaults low rather than holding.
  always_comb begin
    data_d = data_q;
    sout_d = sout_q;
    co_d   = 1'b0;
    if (en) begin
      data_d = next_val;
      co_d   = wrap;
      if (is_shift_mode(mode)) begin
        sout_d = out_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= RST_VAL;
      sout_q <= 1'b0;
      co_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
      co_q   <= co_d;
    end
  end

`ifdef REG_UNIV_CNT_EN
  assign tc = ((mode == MODE_CNT_UP) && (&data_q)) ||
              ((mode == MODE_CNT_DN) && (~|data_q));
`else
  assign tc = 1'b0;
`endif

  assign data_out = data_q;
  assign sout     = sout_q;
  assign co       = co_q;

endmodule

// File: tb/tb_reg_nb_univ.sv
// tb/tb_reg_nb_univ.sv - randomized self-checking bench for reg_nb_univ against an arithmetic model
module tb_reg_nb_univ;

  localparam int N = 8;
  localparam logic [N-1:0] RST = 8'hA5;
`ifdef REG_UNIV_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [N-1:0] data_in = '0;
  logic         sin = 1'b0;
  logic [N-1:0] data_out;
  logic         sout;
  logic         co;
  logic         tc;

  int n_tests = 0;
  int n_fail = 0;

  int m_data = 0;
  int m_sout = 0;
  int m_co = 0;

  reg_nb_univ #(.n(N), .RST_VAL(RST)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .mode     (mode),
    .data_in  (data_in),
    .sin      (sin),
    .data_out (data_out),
    .sout     (sout),
    .co       (co),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_tc(input int md, input int d);
    if (!CNT) return 0;
    if (md == 6 && d == 255) return 1;
    if (md == 7 && d == 0) return 1;
    return 0;
  endfunction

  // Reference behaviour of one clock edge in plain integer arithmetic.
  task automatic model_edge(input int c, input int e, input int md, input int din, input int s);
    int d;
    d = m_data;
    m_co = 0;
    if (c != 0) begin
      m_data = RST;
      m_sout = 0;
    end else if (e != 0) begin
      case (md)
        1: m_data = din;
        2: begin m_sout = d / 128; m_data = (d * 2) % 256 + s; end
        3: begin m_sout = d % 2; m_data = d / 2 + s * 128; end
        4: begin m_sout = d / 128; m_data = (d * 2) % 256 + d / 128; end
        5: begin m_sout = d % 2; m_data = d / 2 + (d % 2) * 128; end
        6: if (CNT) begin m_data = (d + 1) % 256; m_co = (d == 255); end
        7: if (CNT) begin m_data = (d + 255) % 256; m_co = (d == 0); end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input int c, input int e, input int md, input int din, input int s);
    @(negedge clk);
    clr = c[0];
    en = e[0];
    mode = md[2:0];
    data_in = din[7:0];
    sin = s[0];
    #1;
    check({tag, "_tc_pre"}, int'(tc), model_tc(md, m_data));
    @(posedge clk);
    model_edge(c, e, md, din, s);
    #1;
    check({tag, "_data"}, int'(data_out), m_data);
    check({tag, "_sout"}, int'(sout), m_sout);
    check({tag, "_co"}, int'(co), m_co);
    check({tag, "_tc"}, int'(tc), model_tc(md, m_data));
  endtask

  int r_md, r_din, r_sel;

  initial begin
    // Reset with a competing load.
    step("rst", 1, 1, 1, 8'h3C, 0);
    check("rst_val", int'(data_out), 8'hA5);
    check("rst_sout", int'(sout), 0);

    step("ld81", 0, 1, 1, 8'h81, 0);
    step("shl", 0, 1, 2, 0, 0);
    check("shl_fix", int'({sout, data_out}), 9'h102);
    step("ror", 0, 1, 5, 0, 1);
    check("ror_fix", int'({sout, data_out}), 9'h001);
    step("hold_sout", 0, 1, 0, 0, 1);

    step("ldfe", 0, 1, 1, 8'hFE, 0);
    step("up1", 0, 1, 6, 0, 0);
    step("up2", 0, 1, 6, 0, 0);
    step("up3", 0, 1, 6, 0, 0);
`ifdef REG_UNIV_CNT_EN
    check("up_fix", int'({co, data_out}), 9'h001);
`else
    check("nocnt_fix", int'({co, tc, data_out}), 10'h0FE);
`endif

    step("ld00", 0, 1, 1, 8'h00, 0);
    step("dn_hold", 0, 0, 7, 0, 0);
    step("dn_go", 0, 1, 7, 0, 0);
`ifdef REG_UNIV_CNT_EN
    check("dn_fix", int'({co, data_out}), 9'h1FF);
`endif

    step("mid_up", 0, 1, 6, 0, 0);
    step("clr_mid", 1, 1, 6, 0, 0);
    check("clr_mid_fix", int'({co, data_out}), 9'h0A5);

    step("ld10", 0, 1, 1, 8'h10, 0);
    for (int i = 0; i < 3; i++) step("up10", 0, 1, 6, 0, 0);

    for (int i = 0; i < 400; i++) begin
      r_md = $urandom_range(0, 7);
      r_sel = $urandom_range(0, 4);
      case (r_sel)
        0: r_din = 8'h00;
        1: r_din = 8'hFF;
        2: r_din = 8'hFE;
        3: r_din = 8'h01;
        default: r_din = $urandom_range(0, 255);
      endcase
      step("rnd", ($urandom_range(0, 31) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           r_md, r_din, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
